lsu_wb_master: RTL

- Wishbone master stage that sits directly upstream of the wishbone RAM slave and other wishbone slaves.
- Converts the core's load/store request/grant/response protocol into single wishbone classic cycles.
- Handles byte-lane select generation, write-data replication, load extraction with sign/zero extension, misalignment detection and a bus timeout.
- One outstanding transaction at a time.

---
 rtl/lsu_wb_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_wb_master.sv
// Load/store unit to Wishbone classic master: one outstanding access, byte-lane
// steering, load extension, misalignment rejection and bus timeout.
module lsu_wb_master #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_cyc,   w_cyc_nxt;
    logic             r_we,    w_we_nxt;
    logic [31:0]      r_adr,   w_adr_nxt;
    logic [31:0]      r_dat,   w_dat_nxt;
    logic [3:0]       r_sel,   w_sel_nxt;
    logic [1:0]       r_size,  w_size_nxt;
    logic             r_uns,   w_uns_nxt;
    logic [1:0]       r_off,   w_off_nxt;
    logic             r_rvalid, w_rvalid_nxt;
    logic             r_err,   w_err_nxt;
    logic [31:0]      r_rdata, w_rdata_nxt;

    logic             w_illegal;
    logic [3:0]       w_sel_req;
    logic [31:0]      w_dat_req;
    logic [31:0]      w_shift;
    logic [31:0]      w_load;
    logic             w_timeout;

    assign gnt_o = req_i && (r_state == S_IDLE);

    // Request decode: lane selects, replicated store data, alignment check
    always_comb begin
        w_illegal = (size_i == 2'b11) ||
                    ((size_i == 2'b01) && addr_i[0]) ||
                    ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
        case (size_i)
            2'b00:   begin w_sel_req = 4'b0001 << addr_i[1:0]; w_dat_req = {4{wdata_i[7:0]}};  end
            2'b01:   begin w_sel_req = 4'b0011 << addr_i[1:0]; w_dat_req = {2{wdata_i[15:0]}}; end
            default: begin w_sel_req = 4'b1111;                w_dat_req = wdata_i;            end
        endcase
    end

    // Load alignment and extension of the slave's read data
    always_comb begin
        w_shift = wb_dat_i >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_load = r_uns ? {24'd0, w_shift[7:0]}  : {{24{w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_load = r_uns ? {16'd0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_cyc_nxt    = r_cyc;
        w_we_nxt     = r_we;
        w_adr_nxt    = r_adr;
        w_dat_nxt    = r_dat;
        w_sel_nxt    = r_sel;
        w_size_nxt   = r_size;
        w_uns_nxt    = r_uns;
        w_off_nxt    = r_off;
        w_rvalid_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        w_rdata_nxt  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_size_nxt = size_i;
                    w_uns_nxt  = unsigned_i;
                    w_off_nxt  = addr_i[1:0];
                    if (w_illegal) begin
                        w_state_nxt  = S_ERR;
                        w_rvalid_nxt = 1'b1;
                        w_err_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_BUS;
                        w_cnt_nxt   = '0;
                        w_cyc_nxt   = 1'b1;
                        w_we_nxt    = we_i;
                        w_adr_nxt   = {addr_i[31:2], 2'b00};
                        w_dat_nxt   = w_dat_req;
                        w_sel_nxt   = w_sel_req;
                    end
                end
            end
            S_BUS: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (wb_err_i || w_timeout || wb_ack_i) begin
                    w_state_nxt  = S_RESP;
                    w_cyc_nxt    = 1'b0;
                    w_we_nxt     = 1'b0;
                    w_adr_nxt    = 32'd0;
                    w_dat_nxt    = 32'd0;
                    w_sel_nxt    = 4'd0;
                    w_rvalid_nxt = 1'b1;
                    // Error (slave or timeout) outranks a simultaneous ack
                    if (wb_err_i || w_timeout) begin
                        w_err_nxt = 1'b1;
                    end else if (!r_we) begin
                        w_rdata_nxt = w_load;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_adr    <= 32'd0;
            r_dat    <= 32'd0;
            r_sel    <= 4'd0;
            r_size   <= 2'd0;
            r_uns    <= 1'b0;
            r_off    <= 2'd0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cyc    <= w_cyc_nxt;
            r_we     <= w_we_nxt;
            r_adr    <= w_adr_nxt;
            r_dat    <= w_dat_nxt;
            r_sel    <= w_sel_nxt;
            r_size   <= w_size_nxt;
            r_uns    <= w_uns_nxt;
            r_off    <= w_off_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_err    <= w_err_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;

endmodule
